// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
//   BYTE_W            : width of one bitstream byte
//   POS_W             : width of the bit-position counter inside a byte
//   DEFAULT_CHAIN_LEN : default number of chain bits to program
//   state_t           : loader FSM state encoding
package config_loader_pkg;

    localparam int BYTE_W            = 8;
    localparam int POS_W             = 3;
    localparam int DEFAULT_CHAIN_LEN = 20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/cfg_byte_serializer.sv
// Byte shift register feeding the configuration chain, MSB first.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (clears register and position)
//   load     : capture data and restart the bit position
//   shift    : shift left by one and advance the bit position
//   data     : byte to capture
//   msb      : current head bit of the register
//   last_bit : the bit currently at msb is the 8th bit of the byte
module cfg_byte_serializer
    import config_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] data,
    output logic              msb,
    output logic              last_bit
);

    logic [BYTE_W-1:0] sreg;
    logic [POS_W-1:0]  pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            pos  <= '0;
        end else if (load) begin
            sreg <= data;
            pos  <= '0;
        end else if (shift) begin
            sreg <= {sreg[BYTE_W-2:0], 1'b0};
            pos  <= pos + POS_W'(1);
        end
    end

    assign msb      = sreg[BYTE_W-1];
    assign last_bit = (pos == POS_W'(BYTE_W - 1));

endmodule

// File: rtl/config_chain_loader.sv
// Streams a byte-wide bitstream into a serial configuration chain and
// verifies a trailing XOR checksum byte.
// Ports:
//   prog_clk  : clock
//   pReset    : synchronous active-high reset
//   start     : begin a load (honoured in IDLE, DONE, ERROR)
//   abort     : return to IDLE at the next edge
//   in_data   : bitstream byte, MSB first; in_valid qualifies it
//   in_ready  : loader accepts in_data this cycle
//   ccff_head : serial bit into the chain head
//   prog_en   : chain shift enable, one chain bit per high cycle
//   busy      : load in progress
//   done      : load finished, checksum matched
//   error     : load finished, checksum mismatched
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for the next data byte
// SHIFT | shifting one bit per cycle into the chain
// CHECK | waiting for the checksum byte
// DONE  | load complete, checksum matched
// ERROR | load complete, checksum mismatched
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int CNT_W     = 12
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] checksum;
    logic              start_ok;
    logic              accept;
    logic              shifting;
    logic              ser_msb;
    logic              ser_last;

    assign start_ok = start & ~abort & (state inside {IDLE, DONE, ERROR});
    assign accept   = (state == LOAD) & in_valid & ~abort;
    assign shifting = (state == SHIFT);

    cfg_byte_serializer u_serializer (
        .clk      (prog_clk),
        .rst      (pReset),
        .load     (accept),
        .shift    (shifting),
        .data     (in_data),
        .msb      (ser_msb),
        .last_bit (ser_last)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final partial byte leaves SHIFT on the bit count, not the byte
    // position, so its unused LSBs never reach the chain.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LOAD;
            LOAD:              if (in_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (bit_cnt == LAST_CNT) begin
                    state_nxt = CHECK;
                end else if (ser_last) begin
                    state_nxt = LOAD;
                end
            end
            CHECK: begin
                if (in_valid) begin
                    state_nxt = (in_data == checksum) ? DONE : ERROR;
                end
            end
            default:           state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bit_cnt  <= '0;
            checksum <= '0;
        end else if (start_ok) begin
            bit_cnt  <= '0;
            checksum <= '0;
        end else if (!abort) begin
            if (accept) checksum <= checksum ^ in_data;
            if (shifting) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        prog_en   = 1'b0;
        ccff_head = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
            SHIFT: begin prog_en = 1'b1; ccff_head = ser_msb; busy = 1'b1; end
            CHECK: begin in_ready = 1'b1; busy = 1'b1; end
            DONE:  done  = 1'b1;
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

    logic       prog_clk = 1'b0;
    logic       preset;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;

    logic rdy_a, head_a, en_a, busy_a, done_a, err_a;
    logic rdy_b, head_b, en_b, busy_b, done_b, err_b;

    logic sel = 1'b0;
    int   chain_len = 20;
    logic in_ready, ccff_head, prog_en, busy, done, error;

    assign in_ready  = sel ? rdy_b  : rdy_a;
    assign ccff_head = sel ? head_b : head_a;
    assign prog_en   = sel ? en_b   : en_a;
    assign busy      = sel ? busy_b : busy_a;
    assign done      = sel ? done_b : done_a;
    assign error     = sel ? err_b  : err_a;

    always #5 prog_clk = ~prog_clk;

    config_chain_loader #(.CHAIN_LEN(20), .CNT_W(12)) dut_20 (
        .prog_clk (prog_clk), .pReset (preset), .start (start), .abort (abort),
        .in_data (in_data), .in_valid (in_valid), .in_ready (rdy_a),
        .ccff_head (head_a), .prog_en (en_a), .busy (busy_a),
        .done (done_a), .error (err_a)
    );

    config_chain_loader #(.CHAIN_LEN(8), .CNT_W(4)) dut_8 (
        .prog_clk (prog_clk), .pReset (preset), .start (start), .abort (abort),
        .in_data (in_data), .in_valid (in_valid), .in_ready (rdy_b),
        .ccff_head (head_b), .prog_en (en_b), .busy (busy_b),
        .done (done_b), .error (err_b)
    );

    int checks = 0;
    int passed = 0;

    // Chain observer: every prog_en cycle contributes one bit.
    bit got_bits[$];
    int head_glitch = 0;
    always @(negedge prog_clk) begin
        if (prog_en) got_bits.push_back(ccff_head);
        else if (ccff_head) head_glitch++;
    end

    logic [7:0] cur_bytes [0:3];
    int         n_bytes;

    // Reference: chain receives the bytes MSB first, truncated to chain_len bits.
    function automatic bit stream_ok(input int base);
        bit exp_bits[$];
        for (int k = 0; k < n_bytes; k++)
            for (int b = 7; b >= 0; b--)
                if (exp_bits.size() < chain_len) exp_bits.push_back(cur_bytes[k][b]);
        if (got_bits.size() - base != exp_bits.size()) return 1'b0;
        for (int i = 0; i < exp_bits.size(); i++)
            if (got_bits[base + i] !== exp_bits[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] xor_sum();
        logic [7:0] s = 8'h00;
        for (int k = 0; k < n_bytes; k++) s ^= cur_bytes[k];
        return s;
    endfunction

    task automatic begin_load(output int base);
        base  = got_bits.size();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    // Waits for in_ready, holds in_valid low for 'gap' ready cycles, then hands
    // the byte over. Data bytes must show their MSB on the chain the next cycle.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data);
        int t = 0;
        bit stall_bad = 1'b0;
        do begin
            @(negedge prog_clk);
            t++;
        end while (!in_ready && t < 300);
        checks++;
        if (!in_ready) begin
            $display("FAIL ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
            return;
        end
        passed++;
        for (int g = 0; g < gap; g++) begin
            @(negedge prog_clk);
            if (prog_en || !in_ready) stall_bad = 1'b1;
        end
        if (gap > 0) begin
            checks++;
            if (stall_bad !== 1'b0)
                $display("FAIL stall_quiet: activity during in_valid gap=%0b, required 0", stall_bad);
            else passed++;
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge prog_clk); #1;
        in_valid = 1'b0;
        if (is_data) begin
            @(negedge prog_clk);
            checks++;
            if (prog_en !== 1'b1 || ccff_head !== b[7])
                $display("FAIL first_bit_latency: prog_en=%0b head=%0b, required 1 %0b",
                         prog_en, ccff_head, b[7]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        checks++;
        if ({rdy_a, head_a, en_a, busy_a, done_a, err_a} !== 6'b0)
            $display("FAIL reset_outputs_20: got %b, required 000000",
                     {rdy_a, head_a, en_a, busy_a, done_a, err_a});
        else passed++;
        checks++;
        if ({rdy_b, head_b, en_b, busy_b, done_b, err_b} !== 6'b0)
            $display("FAIL reset_outputs_8: got %b, required 000000",
                     {rdy_b, head_b, en_b, busy_b, done_b, err_b});
        else passed++;
        @(posedge prog_clk); #1;
        preset = 1'b0;
    endtask

    task automatic run_full(input logic [7:0] chk, input int gap, input bit exp_done,
                            input string name);
        int base;
        begin_load(base);
        for (int k = 0; k < n_bytes; k++) send_byte(cur_bytes[k], gap, 1'b1);
        send_byte(chk, gap, 1'b0);
        @(negedge prog_clk);
        checks++;
        if (done !== exp_done || error !== !exp_done)
            $display("FAIL %s_result: done=%0b error=%0b, required %0b %0b",
                     name, done, error, exp_done, !exp_done);
        else passed++;
        checks++;
        if (!stream_ok(base))
            $display("FAIL %s_stream: %0d pulses or bit pattern wrong, required %0d pulses",
                     name, got_bits.size() - base, chain_len);
        else passed++;
    endtask

    task automatic test_directed();
        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C; cur_bytes[2] = 8'hF0; n_bytes = 3;
        run_full(8'h69, 0, 1'b1, "good_chk");
        @(negedge prog_clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL done_hold: done=%0b busy=%0b, required 1 0", done, busy);
        else passed++;
    endtask

    task automatic test_bad_checksum();
        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C; cur_bytes[2] = 8'hF0; n_bytes = 3;
        run_full(8'h00, 0, 1'b0, "bad_chk");
    endtask

    task automatic test_gap();
        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C; cur_bytes[2] = 8'hF0; n_bytes = 3;
        run_full(8'h69, 5, 1'b1, "gap");
    endtask

    task automatic test_abort();
        int base;
        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C; cur_bytes[2] = 8'hF0; n_bytes = 3;
        begin_load(base);
        send_byte(cur_bytes[0], 0, 1'b1);
        send_byte(cur_bytes[1], 0, 1'b1);
        @(posedge prog_clk); #1;
        @(posedge prog_clk); #1;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        @(negedge prog_clk);
        checks++;
        if ({prog_en, busy, in_ready, done, error} !== 5'b0)
            $display("FAIL abort_idle: en/busy/rdy/done/err=%b, required 00000",
                     {prog_en, busy, in_ready, done, error});
        else passed++;
        checks++;
        if (got_bits.size() - base != 11)
            $display("FAIL abort_pulses: got %0d, required 11", got_bits.size() - base);
        else passed++;
        run_full(8'h69, 0, 1'b1, "after_abort");
    endtask

    task automatic test_start_in_shift();
        int base;
        cur_bytes[0] = 8'h5A; cur_bytes[1] = 8'hC3; cur_bytes[2] = 8'h0F; n_bytes = 3;
        begin_load(base);
        send_byte(cur_bytes[0], 0, 1'b1);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        send_byte(cur_bytes[1], 0, 1'b1);
        send_byte(cur_bytes[2], 0, 1'b1);
        send_byte(xor_sum(), 0, 1'b0);
        @(negedge prog_clk);
        checks++;
        if (done !== 1'b1 || !stream_ok(base))
            $display("FAIL start_ignored: done=%0b pulses=%0d, required 1 20",
                     done, got_bits.size() - base);
        else passed++;
    endtask

    task automatic test_reset_in_check();
        int base;
        int t = 0;
        cur_bytes[0] = 8'hA5; cur_bytes[1] = 8'h3C; cur_bytes[2] = 8'hF0; n_bytes = 3;
        begin_load(base);
        for (int k = 0; k < 3; k++) send_byte(cur_bytes[k], 0, 1'b1);
        do begin
            @(negedge prog_clk);
            t++;
        end while (!in_ready && t < 50);
        checks++;
        if (busy !== 1'b1 || prog_en !== 1'b0 || got_bits.size() - base != 20)
            $display("FAIL reached_check: busy=%0b en=%0b pulses=%0d, required 1 0 20",
                     busy, prog_en, got_bits.size() - base);
        else passed++;
        in_data = 8'h69; in_valid = 1'b1; preset = 1'b1; start = 1'b1;
        @(posedge prog_clk); #1;
        in_valid = 1'b0; preset = 1'b0; start = 1'b0;
        @(negedge prog_clk);
        checks++;
        if ({in_ready, ccff_head, prog_en, busy, done, error} !== 6'b0)
            $display("FAIL reset_in_check: got %b, required 000000",
                     {in_ready, ccff_head, prog_en, busy, done, error});
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] chk;
            bit bad;
            int gap;
            for (int k = 0; k < 3; k++) cur_bytes[k] = 8'($urandom_range(0, 255));
            n_bytes = 3;
            chk = xor_sum();
            bad = 1'($urandom_range(0, 1));
            if (bad) chk ^= 8'($urandom_range(1, 255));
            gap = $urandom_range(0, 3);
            run_full(chk, gap, !bad, "random");
        end
    endtask

    task automatic test_chain8();
        int base;
        int t = 0;
        sel = 1'b1; chain_len = 8;
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        cur_bytes[0] = 8'hFF; n_bytes = 1;
        begin_load(base);
        send_byte(8'hFF, 0, 1'b1);
        do begin
            @(negedge prog_clk);
            t++;
        end while (!in_ready && t < 50);
        checks++;
        if (got_bits.size() - base != 8 || busy !== 1'b1 || prog_en !== 1'b0)
            $display("FAIL chain8_check: pulses=%0d busy=%0b en=%0b, required 8 1 0",
                     got_bits.size() - base, busy, prog_en);
        else passed++;
        send_byte(8'hFF, 0, 1'b0);
        @(negedge prog_clk);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || !stream_ok(base))
            $display("FAIL chain8_done: done=%0b error=%0b pulses=%0d, required 1 0 8",
                     done, error, got_bits.size() - base);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bad_checksum();
        test_gap();
        test_abort();
        test_start_in_shift();
        test_reset_in_check();
        test_random();
        test_chain8();
        checks++;
        if (head_glitch != 0)
            $display("FAIL head_when_idle: ccff_head high without prog_en %0d times, required 0",
                     head_glitch);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
